qmfir_capture_buf: RTL and testbench

Parametrised multi-channel capture buffer for QM FIR outputs. It replaces the fixed three-BRAM, 128-entry output storage and its hard-wired readback mux. The block stores NCH complex (real/imag) samples per DataValid strobe into per-channel memories, in one-shot or circular mode. It exposes a registered host read port with tagged read data for the UART interface. It sits between the QM_FIR outputs and the UART register/memory readback path.

---
 rtl/qmfir_capture_buf.sv | 196 +++++++++++++++++++
 tb/tb_qmfir_capture_buf.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmfir_capture_buf.sv
// Multi-channel capture buffer for QM FIR outputs.
//
// Stores NCH complex samples (real/imag, DW bits each) per in_valid strobe into
// 2*NCH simple dual-port memories of DEPTH entries. Capture runs one-shot (stops
// when full) or circular (overwrites oldest). A registered host read port returns
// tagged data {sel, index, word} one cycle after host_re.
//
// Ports:
//   core_clk, arst        clock, asynchronous active-high reset
//   in_valid, in_data     sample strobe and packed {imag_c, real_c} words per channel
//   cfg_start/stop/clear  control pulses (priority clear > start > stop)
//   cfg_mode              0 = one-shot, 1 = circular; latched on cfg_start
//   host_re, host_addr    read request, {sel, index}
//   host_rdata, host_rvalid  tagged read data, one-cycle valid pulse
//   wptr, count, full, overrun, busy  capture status
module qmfir_capture_buf #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned IW    = $clog2(DEPTH),
    parameter int unsigned SW    = 4
) (
    input  logic                  core_clk,
    input  logic                  arst,
    input  logic                  in_valid,
    input  logic [NCH*2*DW-1:0]   in_data,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  cfg_clear,
    input  logic                  cfg_mode,
    input  logic                  host_re,
    input  logic [SW+IW-1:0]      host_addr,
    output logic [SW+IW+DW-1:0]   host_rdata,
    output logic                  host_rvalid,
    output logic [IW-1:0]         wptr,
    output logic [IW:0]           count,
    output logic                  full,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned NW     = 2 * NCH;
    localparam logic [IW:0] CntMax = (IW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e          st_q, st_d;
    logic            mode_q, mode_d;
    logic [IW-1:0]   wptr_q, wptr_d;
    logic [IW:0]     count_q, count_d;
    logic            ovr_q, ovr_d;
    logic            full_q;

    logic            wr_en;
    logic [IW-1:0]   wr_idx;

    // ------------------------------------------------------------------
    // Capture control
    // ------------------------------------------------------------------
    always_comb begin
        st_d    = st_q;
        mode_d  = mode_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        wr_en   = 1'b0;
        wr_idx  = wptr_q;

        if (cfg_clear) begin
            st_d    = StIdle;
            wptr_d  = '0;
            count_d = '0;
            ovr_d   = 1'b0;
        end else if (cfg_start) begin
            // Start (or restart) clears status; a coincident sample lands at index 0.
            st_d    = StCapture;
            mode_d  = cfg_mode;
            ovr_d   = 1'b0;
            wr_idx  = '0;
            wr_en   = in_valid;
            wptr_d  = in_valid ? IW'(1) : '0;
            count_d = in_valid ? (IW + 1)'(1) : '0;
        end else begin
            unique case (st_q)
                StCapture: begin
                    if (in_valid) begin
                        wr_en   = 1'b1;
                        wptr_d  = wptr_q + 1'b1;
                        count_d = (count_q == CntMax) ? CntMax : count_q + 1'b1;
                        // One-shot: the write that fills the buffer ends the capture.
                        if (!mode_q && (count_q == CntMax - 1'b1)) begin
                            st_d = StDone;
                        end
                    end
                    if (cfg_stop) begin
                        st_d = StDone;
                    end
                end
                StDone: begin
                    if (in_valid && !mode_q) begin
                        ovr_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge core_clk or posedge arst) begin
        if (arst) begin
            st_q    <= StIdle;
            mode_q  <= 1'b0;
            wptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            mode_q  <= mode_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            full_q  <= (count_d == CntMax);
        end
    end

    assign wptr    = wptr_q;
    assign count   = count_q;
    assign full    = full_q;
    assign overrun = ovr_q;
    assign busy    = (st_q == StCapture);

    // ------------------------------------------------------------------
    // Storage: one simple dual-port RAM per word (word 2c = real, 2c+1 = imag)
    // ------------------------------------------------------------------
    logic [SW-1:0]      rd_sel;
    logic [IW-1:0]      rd_idx;
    logic [NW*DW-1:0]   rd_flat;

    assign rd_sel = host_addr[SW+IW-1:IW];
    assign rd_idx = host_addr[IW-1:0];

    for (genvar k = 0; k < NW; k++) begin : g_mem
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_q;

        // No reset on RAM or its output register so it maps to block RAM;
        // the nonblocking read gives read-first behaviour on address collision.
        always_ff @(posedge core_clk) begin
            if (wr_en) begin
                mem[wr_idx] <= in_data[k*DW +: DW];
            end
            if (host_re) begin
                rd_q <= mem[rd_idx];
            end
        end

        assign rd_flat[k*DW +: DW] = rd_q;
    end

    // ------------------------------------------------------------------
    // Read tag and output select
    // ------------------------------------------------------------------
    logic [SW-1:0]  tag_sel_q;
    logic [IW-1:0]  tag_idx_q;
    logic           rvalid_q;
    logic [DW-1:0]  rd_word;

    always_ff @(posedge core_clk or posedge arst) begin
        if (arst) begin
            tag_sel_q <= '0;
            tag_idx_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= host_re;
            if (host_re) begin
                tag_sel_q <= rd_sel;
                tag_idx_q <= rd_idx;
            end
        end
    end

    // Tag resets to sel 0, which selects no word, so host_rdata is 0 after reset.
    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < NW; k++) begin
            if (tag_sel_q == SW'(k + 1)) begin
                rd_word = rd_flat[k*DW +: DW];
            end
        end
    end

    assign host_rdata  = {tag_sel_q, tag_idx_q, rd_word};
    assign host_rvalid = rvalid_q;

endmodule

// File: tb/tb_qmfir_capture_buf.sv
module tb_qmfir_capture_buf;

    localparam int unsigned NCH   = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned IW    = 7;
    localparam int unsigned SW    = 4;
    localparam int unsigned NW    = 2 * NCH;
    localparam int unsigned AW    = SW + IW;
    localparam int unsigned RW    = SW + IW + DW;

    localparam int MIdle = 0;
    localparam int MCap  = 1;
    localparam int MDone = 2;

    logic                core_clk = 1'b0;
    logic                arst;
    logic                in_valid, cfg_start, cfg_stop, cfg_clear, cfg_mode, host_re;
    logic [NW*DW-1:0]    in_data;
    logic [AW-1:0]       host_addr;
    logic [RW-1:0]       host_rdata;
    logic                host_rvalid, full, overrun, busy;
    logic [IW-1:0]       wptr;
    logic [IW:0]         count;

    qmfir_capture_buf #(
        .NCH  (NCH),
        .DW   (DW),
        .DEPTH(DEPTH),
        .IW   (IW),
        .SW   (SW)
    ) dut (
        .core_clk   (core_clk),
        .arst       (arst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_clear  (cfg_clear),
        .cfg_mode   (cfg_mode),
        .host_re    (host_re),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .wptr       (wptr),
        .count      (count),
        .full       (full),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 core_clk = ~core_clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int             m_state, m_wptr, m_count;
    logic           m_mode, m_ovr;
    logic [DW-1:0]  m_mem [NW][DEPTH];
    logic           e_rvalid;
    logic [RW-1:0]  e_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NW*DW-1:0] mk_data(input logic [DW-1:0] re_v,
                                                 input logic [DW-1:0] im_v);
        logic [NW*DW-1:0] d;
        for (int c = 0; c < NCH; c++) begin
            d[(2*c)*DW +: DW]   = re_v;
            d[(2*c+1)*DW +: DW] = im_v;
        end
        return d;
    endfunction

    task automatic model_reset();
        m_state  = MIdle;
        m_wptr   = 0;
        m_count  = 0;
        m_mode   = 1'b0;
        m_ovr    = 1'b0;
        e_rvalid = 1'b0;
        e_rdata  = '0;
    endtask

    task automatic model_store();
        for (int w = 0; w < NW; w++) m_mem[w][m_wptr] = in_data[w*DW +: DW];
        m_wptr = (m_wptr + 1) % DEPTH;
        if (m_count < DEPTH) m_count++;
    endtask

    // Behaviour at a rising edge, using the inputs held across that edge.
    task automatic model_edge();
        int            s;
        int            ix;
        logic [DW-1:0] dv;
        e_rvalid = host_re;
        if (host_re) begin
            s  = int'(host_addr[AW-1:IW]);
            ix = int'(host_addr[IW-1:0]);
            dv = (s >= 1 && s <= NW) ? m_mem[s-1][ix] : '0;
            e_rdata = {SW'(s), IW'(ix), dv};
        end
        if (cfg_clear) begin
            m_state = MIdle; m_wptr = 0; m_count = 0; m_ovr = 1'b0;
        end else if (cfg_start) begin
            m_state = MCap; m_mode = cfg_mode; m_ovr = 1'b0; m_wptr = 0; m_count = 0;
            if (in_valid) model_store();
        end else if (m_state == MCap) begin
            if (in_valid) begin
                model_store();
                if (!m_mode && m_count == DEPTH) m_state = MDone;
            end
            if (cfg_stop) m_state = MDone;
        end else if (m_state == MDone && in_valid && !m_mode) begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic check_all();
        check("wptr", 64'(wptr), 64'(m_wptr));
        check("count", 64'(count), 64'(m_count));
        check("full", 64'(full), 64'(m_count == DEPTH));
        check("overrun", 64'(overrun), 64'(m_ovr));
        check("busy", 64'(busy), 64'(m_state == MCap));
        check("rvalid", 64'(host_rvalid), 64'(e_rvalid));
        if (e_rvalid) check("rdata", 64'(host_rdata), 64'(e_rdata));
    endtask

    task automatic step(input logic clr, input logic start, input logic stop, input logic v,
                        input logic mode, input logic re, input logic [AW-1:0] addr,
                        input logic [NW*DW-1:0] d);
        @(negedge core_clk);
        cfg_clear = clr; cfg_start = start; cfg_stop = stop; in_valid = v;
        cfg_mode = mode; host_re = re; host_addr = addr; in_data = d;
        @(posedge core_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic rd(input logic [SW-1:0] s, input logic [IW-1:0] ix);
        step(0, 0, 0, 0, 0, 1, {s, ix}, '0);
    endtask

    initial begin
        arst = 1'b1;
        in_valid = 0; cfg_start = 0; cfg_stop = 0; cfg_clear = 0; cfg_mode = 0;
        host_re = 0; host_addr = '0; in_data = '0;
        model_reset();
        #12;
        check("rst_wptr", 64'(wptr), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_flags", 64'({full, overrun, busy, host_rvalid}), 64'd0);
        check("rst_rdata", 64'(host_rdata), 64'd0);
        @(negedge core_clk);
        arst = 1'b0;

        // One-shot fill: real = index, imag = ~index
        step(0, 1, 0, 0, 0, 0, '0, '0);
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 0, 0, 1, 0, 0, '0, mk_data(DW'(k), ~DW'(k)));
        end
        check("os_full", 64'(full), 64'd1);
        check("os_wptr", 64'(wptr), 64'd0);
        check("os_count", 64'(count), 64'd128);
        check("os_busy", 64'(busy), 64'd0);
        rd(4'd3, 7'd5);
        check("os_rd_real", 64'(host_rdata), 64'({4'd3, 7'd5, 16'h0005}));
        rd(4'd4, 7'd5);
        check("os_rd_imag", 64'(host_rdata), 64'({4'd4, 7'd5, 16'hFFFA}));

        // Overrun in one-shot DONE, memory untouched
        step(0, 0, 0, 1, 0, 0, '0, mk_data(16'h1111, 16'h2222));
        step(0, 0, 0, 1, 0, 0, '0, mk_data(16'h3333, 16'h4444));
        check("ovr_set", 64'(overrun), 64'd1);
        rd(4'd1, 7'd0);
        check("ovr_mem", 64'(host_rdata), 64'({4'd1, 7'd0, 16'h0000}));
        step(1, 0, 0, 0, 0, 0, '0, '0);
        check("ovr_clear", 64'(overrun), 64'd0);

        // Circular: 130 writes of value k
        step(0, 1, 0, 0, 1, 0, '0, '0);
        for (int k = 0; k < 130; k++) begin
            step(0, 0, 0, 1, 0, 0, '0, mk_data(DW'(k), DW'(k)));
        end
        check("circ_count", 64'(count), 64'd128);
        check("circ_wptr", 64'(wptr), 64'd2);
        check("circ_busy", 64'(busy), 64'd1);
        rd(4'd1, 7'd0);
        check("circ_idx0", 64'(host_rdata[DW-1:0]), 64'd128);
        rd(4'd6, 7'd2);
        check("circ_idx2", 64'(host_rdata[DW-1:0]), 64'd2);
        step(0, 0, 1, 0, 0, 0, '0, '0);
        check("circ_stop", 64'(busy), 64'd0);

        // Coincident pulses
        step(0, 1, 0, 1, 0, 0, '0, mk_data(16'hABCD, 16'h1234));
        check("start_v_cnt", 64'(count), 64'd1);
        rd(4'd2, 7'd0);
        check("start_v_rd", 64'(host_rdata[DW-1:0]), 64'h1234);
        step(1, 1, 0, 0, 0, 0, '0, '0);
        check("clr_start", 64'(busy), 64'd0);

        // Back-to-back reads, including out-of-range selects
        rd(4'd1, 7'd9);
        rd(4'd0, 7'd9);
        check("sel0", 64'(host_rdata), 64'({4'd0, 7'd9, 16'h0}));
        rd(4'd7, 7'd3);
        check("sel7", 64'(host_rdata), 64'({4'd7, 7'd3, 16'h0}));
        rd(4'd5, 7'd127);

        // Reset mid-capture
        step(0, 1, 0, 0, 0, 0, '0, '0);
        for (int k = 0; k < 40; k++) step(0, 0, 0, 1, 0, 1, {4'd2, IW'(k)}, mk_data(16'h5A5A, DW'(k)));
        check("pre_rst_cnt", 64'(count), 64'd40);
        #2 arst = 1'b1;
        #1;
        model_reset();
        check("arst_wptr", 64'(wptr), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_flags", 64'({full, overrun, busy, host_rvalid}), 64'd0);
        check("arst_rdata", 64'(host_rdata), 64'd0);
        @(negedge core_clk);
        arst = 1'b0;
        step(0, 1, 0, 0, 0, 0, '0, '0);
        check("restart_wptr", 64'(wptr), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NW*DW-1:0] d;
            for (int w = 0; w < NW; w++) d[w*DW +: DW] = DW'($urandom);
            step($urandom_range(999) < 3, $urandom_range(999) < 5, $urandom_range(999) < 5,
                 $urandom_range(99) < 60, 1'($urandom), 1'($urandom),
                 {SW'($urandom_range(15)), IW'($urandom)}, d);
        end
        idle_step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
